pipeline_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage ARM core. It generates the freeze and flush controls for the PC register and the IF, ID, EXE and MEM stage registers. The controls cover three cases: load-use and non-forwardable data hazards, taken-branch redirects resolved in EXE, and multi-cycle data-memory (SRAM) waits. It also keeps a memory-wait watchdog and saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 18 +
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 49 ++++
 rtl/pipeline_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared constants for the pipeline sequencer: register-number width, default
// performance-counter width and the two sequencer FSM state codes.
// No ports.
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

   // Architectural register number width (16 GPRs)
   localparam int REG_W     = 4;
   // Default width of the stall / flush performance counters
   localparam int CNT_W_DEF = 16;

   // Sequencer FSM encoding
   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational source/destination compare between the instruction in
// ID and the instructions in EXE and MEM.
// Ports:
//   id_src1_i, id_src2_i   ID source register numbers
//   id_two_src_i           ID instruction also reads id_src2_i
//   exe_wb_en_i            EXE instruction writes back
//   exe_mem_read_i         EXE instruction is a load
//   exe_dest_i             EXE destination register
//   mem_wb_en_i            MEM instruction writes back
//   mem_dest_i             MEM destination register
//   forward_en_i           forwarding unit enabled
//   hazard_o               data hazard (before control priority)
// -----------------------------------------------------------------------------
module hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] id_src1_i,
   input  logic [REG_W-1:0] id_src2_i,
   input  logic             id_two_src_i,
   input  logic             exe_wb_en_i,
   input  logic             exe_mem_read_i,
   input  logic [REG_W-1:0] exe_dest_i,
   input  logic             mem_wb_en_i,
   input  logic [REG_W-1:0] mem_dest_i,
   input  logic             forward_en_i,
   output logic             hazard_o
);

   logic exe_match;
   logic mem_match;
   logic exe_hazard;
   logic mem_hazard;

   // Second source only counts when the instruction actually reads it
   assign exe_match = (id_src1_i == exe_dest_i) |
                      (id_two_src_i & (id_src2_i == exe_dest_i));
   assign mem_match = (id_src1_i == mem_dest_i) |
                      (id_two_src_i & (id_src2_i == mem_dest_i));

   // A load result in EXE cannot be forwarded yet, so it stalls even with
   // forwarding on; everything else only stalls when forwarding is off.
   assign exe_hazard = exe_match & exe_wb_en_i & (~forward_en_i | exe_mem_read_i);
   assign mem_hazard = mem_match & mem_wb_en_i & ~forward_en_i;

   assign hazard_o = exe_hazard | mem_hazard;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central sequencer for the 5-stage core: freeze/flush controls for PC and
// the IF/ID/EXE/MEM stage registers, a memory-wait watchdog and saturating
// stall/flush performance counters.
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   id_src1, id_src2, id_two_src  ID source operands
//   exe_wb_en, exe_mem_read, exe_dest   EXE writer info
//   mem_wb_en, mem_dest           MEM writer info
//   forward_en                    forwarding unit enabled
//   branch_taken                  taken branch resolved in EXE
//   mem_req, mem_ready            SRAM request / completion
//   pc_freeze, if_reg_freeze, id_reg_freeze, exe_reg_freeze, mem_reg_freeze
//   if_reg_flush, id_reg_flush
//   hazard                        raw data hazard
//   mem_timeout                   sticky memory-wait watchdog flag
//   stall_cycles, flush_count     saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic             exe_wb_en,
   input  logic             exe_mem_read,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             mem_wb_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             forward_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_freeze,
   output logic             if_reg_freeze,
   output logic             if_reg_flush,
   output logic             id_reg_flush,
   output logic             id_reg_freeze,
   output logic             exe_reg_freeze,
   output logic             mem_reg_freeze,
   output logic             hazard,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   logic             mem_stall;
   logic [0:0]       state_q,   state_d;
   logic [CNT_W-1:0] wait_q,    wait_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_q,   stall_d;
   logic [CNT_W-1:0] flush_q,   flush_d;

   hazard_detect u_hazard_detect (
      .id_src1_i      (id_src1),
      .id_src2_i      (id_src2),
      .id_two_src_i   (id_two_src),
      .exe_wb_en_i    (exe_wb_en),
      .exe_mem_read_i (exe_mem_read),
      .exe_dest_i     (exe_dest),
      .mem_wb_en_i    (mem_wb_en),
      .mem_dest_i     (mem_dest),
      .forward_en_i   (forward_en),
      .hazard_o       (hazard)
   );

   assign mem_stall = mem_req & ~mem_ready;

   // Priority mux: memory stall > taken branch > data hazard. Everything is
   // held at zero while reset is asserted.
   always_comb begin
      pc_freeze      = 1'b0;
      if_reg_freeze  = 1'b0;
      id_reg_freeze  = 1'b0;
      exe_reg_freeze = 1'b0;
      mem_reg_freeze = 1'b0;
      if_reg_flush   = 1'b0;
      id_reg_flush   = 1'b0;
      if (rst) begin
         if (mem_stall) begin
            pc_freeze      = 1'b1;
            if_reg_freeze  = 1'b1;
            id_reg_freeze  = 1'b1;
            exe_reg_freeze = 1'b1;
            mem_reg_freeze = 1'b1;
         end else if (branch_taken) begin
            if_reg_flush = 1'b1;
            id_reg_flush = 1'b1;
         end else if (hazard) begin
            // Hold PC/IF and inject a bubble into ID->EXE
            pc_freeze     = 1'b1;
            if_reg_freeze = 1'b1;
            id_reg_flush  = 1'b1;
         end
      end
   end

   // Memory-wait FSM and watchdog. The wait counter is cleared on return to
   // RUN so a later wait always starts counting from 1.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_RUN: begin
            if (mem_stall) begin
               state_d = ST_MEM_WAIT;
               wait_d  = CNT_W'(1);
            end
         end
         default: begin
            if (!mem_stall) begin
               state_d = ST_RUN;
               wait_d  = '0;
            end else if (wait_q != TIMEOUT_C) begin
               wait_d = wait_q + CNT_W'(1);
            end
            if (mem_stall && (wait_q == TIMEOUT_C)) begin
               timeout_d = 1'b1;
            end
         end
      endcase
   end

   // Saturating performance counters
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (pc_freeze && !(&stall_q)) begin
         stall_d = stall_q + CNT_W'(1);
      end
      if (if_reg_flush && !(&flush_q)) begin
         flush_d = flush_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   assign mem_timeout  = timeout_q;
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 3;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [3:0]       id_src1, id_src2, exe_dest, mem_dest;
   logic             id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
   logic             forward_en, branch_taken, mem_req, mem_ready;
   logic             pc_freeze, if_reg_freeze, if_reg_flush, id_reg_flush;
   logic             id_reg_freeze, exe_reg_freeze, mem_reg_freeze;
   logic             hazard, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_count;

   int n_cmp = 0;
   int n_bad = 0;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_src1        (id_src1),
      .id_src2        (id_src2),
      .id_two_src     (id_two_src),
      .exe_wb_en      (exe_wb_en),
      .exe_mem_read   (exe_mem_read),
      .exe_dest       (exe_dest),
      .mem_wb_en      (mem_wb_en),
      .mem_dest       (mem_dest),
      .forward_en     (forward_en),
      .branch_taken   (branch_taken),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .pc_freeze      (pc_freeze),
      .if_reg_freeze  (if_reg_freeze),
      .if_reg_flush   (if_reg_flush),
      .id_reg_flush   (id_reg_flush),
      .id_reg_freeze  (id_reg_freeze),
      .exe_reg_freeze (exe_reg_freeze),
      .mem_reg_freeze (mem_reg_freeze),
      .hazard         (hazard),
      .mem_timeout    (mem_timeout),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Raw hazard: any read operand that is being produced by an instruction
   // whose value is not yet available through forwarding.
   function automatic bit model_hazard();
      bit h = 0;
      int srcs[$];
      srcs.push_back(int'(id_src1));
      if (id_two_src) srcs.push_back(int'(id_src2));
      foreach (srcs[k]) begin
         if (exe_wb_en && srcs[k] == int'(exe_dest) && (!forward_en || exe_mem_read)) h = 1;
         if (mem_wb_en && srcs[k] == int'(mem_dest) && !forward_en) h = 1;
      end
      return h;
   endfunction

   // Control word {pc, if_frz, id_frz, exe_frz, mem_frz, if_flush, id_flush}
   function automatic logic [6:0] model_ctrl();
      if (!rst)                    return 7'b0000000;
      if (mem_req && !mem_ready)   return 7'b1111100;
      if (branch_taken)            return 7'b0000011;
      if (model_hazard())          return 7'b1100001;
      return 7'b0000000;
   endfunction

   int m_stall = 0;  // expected stall_cycles
   int m_flush = 0;  // expected flush_count
   int m_run   = 0;  // consecutive stall cycles completed so far
   bit m_to    = 0;  // expected mem_timeout

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
      end else begin
         logic [6:0] c;
         c = model_ctrl();
         if (c[6] && m_stall < CMAX) m_stall++;
         if (c[1] && m_flush < CMAX) m_flush++;
         if (mem_req && !mem_ready) begin
            if (m_run >= TIMEOUT) m_to = 1;
            m_run++;
         end else begin
            m_run = 0;
         end
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      chk("ctrl_word",
          int'({pc_freeze, if_reg_freeze, id_reg_freeze, exe_reg_freeze,
                mem_reg_freeze, if_reg_flush, id_reg_flush}),
          int'(model_ctrl()));
      chk("hazard", int'(hazard), int'(model_hazard()));
      chk("mem_timeout", int'(mem_timeout), int'(m_to));
      chk("stall_cycles", int'(stall_cycles), m_stall);
      chk("flush_count", int'(flush_count), m_flush);
   end

   // ---------------- directed stimulus ----------------
   task automatic idle();
      id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
      exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_dest = 4'd0;
      mem_wb_en = 1'b0; mem_dest = 4'd0; forward_en = 1'b1;
      branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use();
      exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
      id_src1 = 4'd3; forward_en = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      idle();
      tick(); tick();
      chk("rst_stall_cycles", int'(stall_cycles), 0);
      chk("rst_flush_count", int'(flush_count), 0);
      mem_req = 1'b1;
      #1;
      chk("rst_pc_freeze_forced", int'(pc_freeze), 0);
      mem_req = 1'b0;
      tick();
      rst = 1'b1;

      // Load-use bubble lasts one cycle
      load_use();
      #1;
      chk("lu_pc_freeze", int'(pc_freeze), 1);
      chk("lu_id_flush", int'(id_reg_flush), 1);
      chk("lu_if_flush", int'(if_reg_flush), 0);
      tick();
      exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_dest = 4'd0;
      #1;
      chk("lu_bubble_clears", int'(pc_freeze), 0);
      chk("lu_stall_cycles", int'(stall_cycles), 1);

      // Forwarding off, MEM-stage match on second source
      forward_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd5;
      id_src2 = 4'd5; id_two_src = 1'b1;
      #1;
      chk("mem_src2_hazard", int'(hazard), 1);
      tick();
      id_two_src = 1'b0;
      #1;
      chk("mem_src2_ignored", int'(hazard), 0);
      chk("mem_stall_cycles", int'(stall_cycles), 2);
      tick();
      idle();

      // Branch overrides hazard
      load_use();
      branch_taken = 1'b1;
      #1;
      chk("br_if_flush", int'(if_reg_flush), 1);
      chk("br_id_flush", int'(id_reg_flush), 1);
      chk("br_pc_freeze", int'(pc_freeze), 0);
      chk("br_raw_hazard", int'(hazard), 1);
      tick();
      idle();
      #1;
      chk("br_flush_count", int'(flush_count), 1);
      chk("br_stall_unchanged", int'(stall_cycles), 2);

      // Fresh counters, then a 4-cycle memory wait
      rst = 1'b0;
      #1;
      chk("rst_clears_stall", int'(stall_cycles), 0);
      tick();
      rst = 1'b1;
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      chk("mw_mem_freeze", int'(mem_reg_freeze), 1);
      repeat (4) tick();
      mem_ready = 1'b1;
      #1;
      chk("mw_ready_no_freeze", int'(pc_freeze), 0);
      chk("mw_stall_cycles", int'(stall_cycles), 4);
      tick();
      mem_req = 1'b0; mem_ready = 1'b0;
      #1;
      chk("mw_stall_cycles_hold", int'(stall_cycles), 4);

      // Watchdog
      rst = 1'b0;
      tick();
      rst = 1'b1;
      mem_req = 1'b1; mem_ready = 1'b0;
      repeat (3) tick();
      chk("wd_not_yet", int'(mem_timeout), 0);
      tick();
      chk("wd_set", int'(mem_timeout), 1);
      tick();
      mem_ready = 1'b1;
      tick();
      mem_req = 1'b0; mem_ready = 1'b0;
      #1;
      chk("wd_sticky", int'(mem_timeout), 1);
      chk("wd_stall_cycles", int'(stall_cycles), 5);

      // Reset in the middle of a wait
      mem_req = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_freeze", int'(pc_freeze), 0);
      chk("mid_rst_timeout", int'(mem_timeout), 0);
      chk("mid_rst_stall", int'(stall_cycles), 0);
      tick();
      rst = 1'b1;
      tick();
      mem_req = 1'b0;
      tick();

      // Branch held behind a memory stall
      mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
      #1;
      chk("bs_no_flush", int'(if_reg_flush), 0);
      chk("bs_freeze", int'(pc_freeze), 1);
      tick(); tick();
      mem_ready = 1'b1;
      #1;
      chk("bs_flush_on_ready", int'(if_reg_flush), 1);
      tick();
      idle();

      // Ready in the same cycle as the request
      mem_req = 1'b1; mem_ready = 1'b1;
      #1;
      chk("same_cycle_ready", int'(pc_freeze), 0);
      tick();
      idle();

      // Flush counter saturation
      rst = 1'b0;
      tick();
      rst = 1'b1;
      branch_taken = 1'b1;
      repeat (20) tick();
      chk("flush_sat", int'(flush_count), 15);
      idle();
      tick();
      chk("flush_sat_hold", int'(flush_count), 15);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
